// File: rtl/ehl_gpio_irq_if.sv
// ehl_gpio_irq_if -- bundle of the GPIO interrupt block's configuration,
// pad and status signals. The master side (CPU/register block or bench)
// drives pads and configuration. The slave side (ehl_gpio_irq) returns
// the filtered input value, the pending register and the interrupt line.
interface ehl_gpio_irq_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] gpio_in;
  logic [WIDTH-1:0] irq_en;
  logic [WIDTH-1:0] irq_type;
  logic [WIDTH-1:0] irq_pol;
  logic [WIDTH-1:0] irq_both;
  logic [WIDTH-1:0] clr_pend;
  logic [WIDTH-1:0] set_pend;
  logic [WIDTH-1:0] gpio_sync;
  logic [WIDTH-1:0] pending;
  logic             irq;

  modport master (
    output gpio_in, irq_en, irq_type, irq_pol, irq_both, clr_pend, set_pend,
    input  gpio_sync, pending, irq
  );

  modport slave (
    input  gpio_in, irq_en, irq_type, irq_pol, irq_both, clr_pend, set_pend,
    output gpio_sync, pending, irq
  );
endinterface

// File: rtl/ehl_gpio_irq.sv
// ehl_gpio_irq -- per-bit GPIO input synchronizer, edge/level interrupt
// detector and pending register with a masked interrupt output.
//
// Optional feature: define EHL_GPIO_DEBOUNCE_EN to add a per-bit debounce
// filter between the synchronizer and gpio_sync. In that build a change must
// be stable for DEB_LEN cycles before it is accepted. In the default build
// DEB_LEN has no effect and no counter logic is generated.
//
// SYNC_STAGES must be at least 2 and DEB_LEN at least 1.
module ehl_gpio_irq #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_LEN     = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  ehl_gpio_irq_if.slave  bus
);

  // Synchronizer chain, stage 0 samples the pad, last stage is the output.
  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]                  w_sync_out;
  // Filtered input value as seen by the detectors.
  logic [WIDTH-1:0]                  w_gpio_sync;
  // Value of w_gpio_sync one cycle earlier, for edge detection.
  logic [WIDTH-1:0]                  r_prev;
  logic [WIDTH-1:0]                  r_pending;

  logic [WIDTH-1:0]                  w_rise;
  logic [WIDTH-1:0]                  w_fall;
  logic [WIDTH-1:0]                  w_edge_evt;
  logic [WIDTH-1:0]                  w_level_evt;
  logic [WIDTH-1:0]                  w_event;

  // Shift raw pad values through the metastability chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], bus.gpio_in};
    end
  end

  assign w_sync_out = r_sync[SYNC_STAGES-1];

`ifdef EHL_GPIO_DEBOUNCE_EN
  localparam int               CNT_W    = $clog2(DEB_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_LEN - 1);

  logic [CNT_W-1:0] r_deb_cnt [WIDTH];
  logic [WIDTH-1:0] r_gpio_sync;

  // Accept a new synchronized value only after it has differed from the
  // current filtered value for DEB_LEN consecutive cycles; any return to the
  // filtered value restarts the count, so short glitches never pass.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        r_deb_cnt[i] <= '0;
      end
      r_gpio_sync <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (w_sync_out[i] == r_gpio_sync[i]) begin
          r_deb_cnt[i] <= '0;
        end else if (r_deb_cnt[i] == CNT_LAST) begin
          r_gpio_sync[i] <= w_sync_out[i];
          r_deb_cnt[i]   <= '0;
        end else begin
          r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  assign w_gpio_sync = r_gpio_sync;
`else
  // The last synchronizer stage is already a register, so it serves
  // directly as gpio_sync.
  assign w_gpio_sync = w_sync_out;
`endif

  // Edge terms compare the current filtered value with last cycle's.
  assign w_rise = w_gpio_sync & ~r_prev;
  assign w_fall = ~w_gpio_sync & r_prev;

  // Edge mode: both-edge select overrides polarity. Level mode: active while
  // the filtered input matches the programmed polarity.
  assign w_edge_evt  = (bus.irq_both & (w_rise | w_fall))
                     | (~bus.irq_both & bus.irq_pol & w_rise)
                     | (~bus.irq_both & ~bus.irq_pol & w_fall);
  assign w_level_evt = ~(w_gpio_sync ^ bus.irq_pol);
  assign w_event     = (bus.irq_type & w_edge_evt) | (~bus.irq_type & w_level_evt);

  // Track the previous filtered value and update pending; a new event or a
  // software set in the same cycle as a clear keeps the bit set.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev    <= '0;
      r_pending <= '0;
    end else begin
      r_prev    <= w_gpio_sync;
      r_pending <= (r_pending & ~bus.clr_pend) | w_event | bus.set_pend;
    end
  end

  assign bus.gpio_sync = w_gpio_sync;
  assign bus.pending   = r_pending;
  // Mask applies only to the interrupt line, never to pending recording.
  assign bus.irq       = |(r_pending & bus.irq_en);

endmodule

// File: tb/tb_ehl_gpio_irq.sv
// tb_ehl_gpio_irq -- scoreboard bench for ehl_gpio_irq. Stimulus pushes
// the expected pending / gpio_sync / irq values for a future cycle into a
// queue. A negedge monitor pops each entry on its cycle and compares it.
// Asynchronous reset behaviour is checked directly.
module tb_ehl_gpio_irq;
  localparam int WIDTH = 32;
  localparam int SS    = 2;
  localparam int DEB   = 4;
`ifdef EHL_GPIO_DEBOUNCE_EN
  localparam int LAT   = SS + DEB;
`else
  localparam int LAT   = SS;
`endif

  localparam int PEND = 0;
  localparam int SYNC = 1;
  localparam int IRQ  = 2;

  typedef struct {
    int          cyc;
    string       tag;
    int          kind;
    logic [31:0] mask;
    logic [31:0] val;
  } exp_t;

  logic clk;
  logic reset_n;
  int   cyc;
  int   n_checks;
  int   n_errors;
  exp_t sb_q[$];

  ehl_gpio_irq_if #(.WIDTH(WIDTH)) bus ();

  ehl_gpio_irq #(
    .WIDTH      (WIDTH),
    .SYNC_STAGES(SS),
    .DEB_LEN    (DEB)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, act, want, cyc);
    end
  endtask

  function automatic logic [31:0] sample(input int kind);
    case (kind)
      PEND:    return bus.pending;
      SYNC:    return bus.gpio_sync;
      default: return {31'b0, bus.irq};
    endcase
  endfunction

  task automatic expect_at(input int d, input string tag, input int kind,
                           input logic [31:0] mask, input logic [31:0] val);
    exp_t e;
    e.cyc  = cyc + d;
    e.tag  = tag;
    e.kind = kind;
    e.mask = mask;
    e.val  = val;
    sb_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compare every entry due this cycle.
  always @(negedge clk) begin
    int   idx;
    exp_t e;
    idx = 0;
    while (idx < sb_q.size()) begin
      e = sb_q[idx];
      if (e.cyc <= cyc) begin
        check((e.cyc == cyc) ? e.tag : {e.tag, "_late"},
              sample(e.kind) & e.mask, e.val & e.mask);
        sb_q.delete(idx);
      end else begin
        idx++;
      end
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    bus.gpio_in  = '0;
    bus.irq_en   = '1;
    bus.irq_type = '1;
    bus.irq_pol  = '1;
    bus.irq_both = '0;
    bus.clr_pend = '0;
    bus.set_pend = '1;
    reset_n = 1'b0;

    // Reset holds state at zero even with software sets and mask open.
    tick(3);
    check("rst_pend", bus.pending, 32'h0);
    check("rst_sync", bus.gpio_sync, 32'h0);
    check("rst_irq", {31'b0, bus.irq}, 32'h0);
    bus.set_pend = '0;
    bus.irq_en   = '0;
    reset_n = 1'b1;
    expect_at(1, "idle_pend", PEND, '1, 32'h0);
    expect_at(LAT + 2, "idle_pend2", PEND, '1, 32'h0);
    tick(LAT + 3);

    // Rising edge on bit 3.
    bus.irq_en = 32'h8;
    bus.gpio_in[3] = 1'b1;
    expect_at(LAT - 1, "t1_sync_early", SYNC, 32'h8, 32'h0);
    expect_at(LAT, "t1_sync", SYNC, 32'h8, 32'h8);
    expect_at(LAT, "t1_pend_early", PEND, '1, 32'h0);
    expect_at(LAT, "t1_irq_early", IRQ, 32'h1, 32'h0);
    expect_at(LAT + 1, "t1_pend", PEND, '1, 32'h8);
    expect_at(LAT + 1, "t1_irq", IRQ, 32'h1, 32'h1);
    tick(LAT + 2);
    bus.clr_pend = 32'h8;
    expect_at(1, "t1_clr", PEND, '1, 32'h0);
    expect_at(1, "t1_irq_clr", IRQ, 32'h1, 32'h0);
    tick(1);
    bus.clr_pend = '0;
    // Falling edge on a rising-only bit produces nothing.
    bus.gpio_in[3] = 1'b0;
    expect_at(LAT, "t1_fall_sync", SYNC, 32'h8, 32'h0);
    expect_at(LAT + 1, "t1_fall_pend", PEND, '1, 32'h0);
    expect_at(LAT + 2, "t1_fall_pend2", PEND, '1, 32'h0);
    tick(LAT + 3);

    // Clear colliding with a new event on bit 0.
    bus.gpio_in[0] = 1'b1;
    expect_at(LAT + 1, "t2_first", PEND, '1, 32'h1);
    tick(LAT + 2);
    bus.gpio_in[0] = 1'b0;
    tick(LAT + 2);
    expect_at(0, "t2_hold", PEND, '1, 32'h1);
    bus.gpio_in[0] = 1'b1;
    tick(LAT);
    bus.clr_pend[0] = 1'b1;
    expect_at(1, "t2_collide", PEND, '1, 32'h1);
    tick(1);
    bus.clr_pend = '0;
    bus.clr_pend[0] = 1'b1;
    expect_at(1, "t2_clr", PEND, '1, 32'h0);
    tick(1);
    bus.clr_pend = '0;
    tick(1);

    // Level-low mode on bit 5: clear is ineffective while the level persists.
    bus.irq_type[5] = 1'b0;
    bus.irq_pol[5]  = 1'b0;
    expect_at(1, "t3_level", PEND, 32'h20, 32'h20);
    tick(2);
    bus.clr_pend[5] = 1'b1;
    expect_at(1, "t3_clr_hold", PEND, 32'h20, 32'h20);
    tick(1);
    bus.clr_pend = '0;
    bus.gpio_in[5] = 1'b1;
    tick(LAT + 1);
    expect_at(0, "t3_sync", SYNC, 32'h20, 32'h20);
    bus.clr_pend[5] = 1'b1;
    expect_at(1, "t3_clr", PEND, '1, 32'h0);
    tick(1);
    bus.clr_pend = '0;
    expect_at(1, "t3_stay", PEND, '1, 32'h0);
    bus.irq_type[5] = 1'b1;
    bus.irq_pol[5]  = 1'b1;
    tick(2);

    // Software trigger while masked, then unmask with zero latency.
    bus.irq_en   = '0;
    bus.set_pend = 32'h0000_0100;
    expect_at(1, "t4_pend", PEND, '1, 32'h0000_0100);
    expect_at(1, "t4_irq_masked", IRQ, 32'h1, 32'h0);
    tick(1);
    bus.set_pend = '0;
    tick(1);
    bus.irq_en[8] = 1'b1;
    expect_at(0, "t4_irq", IRQ, 32'h1, 32'h1);
    tick(1);

    // Both-edge mode on bit 1 (polarity ignored); config change keeps pending.
    bus.irq_both[1] = 1'b1;
    bus.irq_pol[1]  = 1'b0;
    expect_at(1, "cfg_keep", PEND, 32'h100, 32'h100);
    bus.gpio_in[1] = 1'b1;
    expect_at(LAT + 1, "t5_rise", PEND, 32'h2, 32'h2);
    tick(LAT + 2);
    bus.clr_pend = 32'h2;
    expect_at(1, "t5_clr1", PEND, 32'h2, 32'h0);
    tick(1);
    bus.clr_pend = '0;
    bus.gpio_in[1] = 1'b0;
    expect_at(LAT, "t5_fall_early", PEND, 32'h2, 32'h0);
    expect_at(LAT + 1, "t5_fall", PEND, 32'h2, 32'h2);
    tick(LAT + 2);
    bus.clr_pend = 32'h2;
    expect_at(1, "t5_clr2", PEND, 32'h2, 32'h0);
    tick(1);
    bus.clr_pend = '0;

    // Reset asserted mid-synchronization clears everything at once.
    bus.gpio_in[1] = 1'b1;
    tick(1);
    check("t5_pre_irq", {31'b0, bus.irq}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("t5_rst_pend", bus.pending, 32'h0);
    check("t5_rst_sync", bus.gpio_sync, 32'h0);
    check("t5_rst_irq", {31'b0, bus.irq}, 32'h0);
    tick(2);

    // Inputs held high through release give exactly one rising event.
    reset_n = 1'b1;
    expect_at(LAT - 1, "t6_sync_early", SYNC, 32'h23, 32'h0);
    expect_at(LAT, "t6_sync", SYNC, 32'h23, 32'h23);
    expect_at(LAT, "t6_pend_early", PEND, '1, 32'h0);
    expect_at(LAT + 1, "t6_rise", PEND, '1, 32'h23);
    expect_at(LAT + 1, "t6_irq", IRQ, 32'h1, 32'h0);
    tick(LAT + 2);
    bus.clr_pend = '1;
    expect_at(1, "t6_clr", PEND, '1, 32'h0);
    expect_at(3, "t6_no_repeat", PEND, '1, 32'h0);
    tick(1);
    bus.clr_pend = '0;
    tick(4);

`ifdef EHL_GPIO_DEBOUNCE_EN
    // A 3-cycle glitch is filtered; a 10-cycle pulse passes after DEB cycles.
    bus.gpio_in[2] = 1'b1;
    for (int d = 1; d <= SS + DEB + 3; d++) begin
      expect_at(d, "deb_glitch_sync", SYNC, 32'h4, 32'h0);
    end
    expect_at(SS + DEB + 4, "deb_glitch_pend", PEND, 32'h4, 32'h0);
    tick(3);
    bus.gpio_in[2] = 1'b0;
    tick(SS + DEB + 4);
    bus.gpio_in[2] = 1'b1;
    expect_at(SS + DEB - 1, "deb_early", SYNC, 32'h4, 32'h0);
    expect_at(SS + DEB, "deb_rise", SYNC, 32'h4, 32'h4);
    expect_at(SS + DEB + 1, "deb_pend", PEND, 32'h4, 32'h4);
    tick(10);
    bus.gpio_in[2] = 1'b0;
    tick(SS + DEB + 3);
`endif

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) begin
      tick(1);
    end
    check("sb_drain", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/ehl_gpio_irq.md
EHL_GPIO_IRQ -- requirements
Module: ehl_gpio_irq

Interface
REQ-001 Parameter WIDTH, default 32, sets the number of GPIO bits handled.
REQ-002 Parameter SYNC_STAGES, default 2, minimum 2, sets the synchronizer flip-flop depth per bit.
REQ-003 Parameter DEB_LEN, default 4, minimum 1, sets the debounce stable-cycle count; it is used only when the debounce feature is compiled in.
REQ-004 Port list SHALL be:
  - clk  input  1  single clock; all state is rising-edge triggered.
  - reset_n  input  1  asynchronous active-low reset.
  - gpio_in  input  WIDTH  raw pad inputs, asynchronous to clk.
  - irq_en  input  WIDTH  per-bit interrupt mask, 1 = enabled.
  - irq_type  input  WIDTH  per-bit mode, 1 = edge, 0 = level.
  - irq_pol  input  WIDTH  per-bit polarity, 1 = rising/high, 0 = falling/low.
  - irq_both  input  WIDTH  per-bit both-edge select, edge mode only; overrides irq_pol.
  - clr_pend  input  WIDTH  one-cycle write-1-to-clear pulses for pending bits.
  - set_pend  input  WIDTH  one-cycle software-trigger pulses for pending bits.
  - gpio_sync  output  WIDTH  synchronized (and filtered) input value, registered.
  - pending  output  WIDTH  interrupt pending register.
  - irq  output  1  combinational OR of (pending & irq_en).
REQ-005 The block SHALL use one clock, clk, and an asynchronous active-low reset, reset_n.

Function
REQ-006 Each gpio_in bit SHALL pass through a SYNC_STAGES flip-flop chain; without debounce, gpio_sync equals the last chain stage.
REQ-007 A change on gpio_in SHALL appear on gpio_sync exactly SYNC_STAGES clk edges after the change is first sampled.
REQ-008 A per-bit register prev SHALL hold the gpio_sync value from the previous cycle.
REQ-009 Detection terms, evaluated per bit:
  - rise = gpio_sync & ~prev.
  - fall = ~gpio_sync & prev.
REQ-010 The event term SHALL be computed per bit as follows:
  - Edge mode with irq_both = 1: event = rise | fall.
  - Edge mode with irq_both = 0: event = rise if irq_pol = 1, fall if irq_pol = 0.
  - Level mode: event = (gpio_sync == irq_pol).
REQ-011 The pending update SHALL be pending <= (pending & ~clr_pend) | event | set_pend, so set/event wins over a simultaneous clear and no event is lost.
REQ-012 An event SHALL set its pending bit on the clk edge following the cycle in which gpio_sync changed, one cycle after gpio_sync updates.
REQ-013 Pending bits SHALL record events regardless of irq_en; irq_en masks only the irq output.
REQ-014 In level mode, clr_pend SHALL be ineffective while the active level persists, and the pending bit SHALL remain 1.
REQ-015 Changing irq_type, irq_pol or irq_both SHALL NOT clear pending; any event produced by the new configuration sets pending on the next edge.
REQ-016 irq SHALL have zero cycles of latency from pending or irq_en.

Reset
REQ-017 reset_n low SHALL asynchronously clear all of the following to 0, and hold them at 0 while reset_n is low:
  - synchronizer chains
  - prev
  - gpio_sync
  - pending
  - debounce counters
REQ-018 irq SHALL be 0 during reset.
REQ-019 An input held high through reset release SHALL produce one rising event, setting pending SYNC_STAGES+1 cycles after the first clk edge after release.
REQ-020 Reset asserted mid-debounce or mid-synchronization SHALL discard partial state; no event is generated from it.

Configuration
REQ-021 Macro EHL_GPIO_DEBOUNCE_EN SHALL compile in per-bit debounce behaviour:
  - Each bit has a counter of width $clog2(DEB_LEN+1).
  - The counter resets to 0 whenever the synchronizer output equals gpio_sync, and otherwise increments.
  - gpio_sync takes the synchronizer output when the count reaches DEB_LEN-1, and the counter is then cleared.
  - The added latency is DEB_LEN cycles.
  - A glitch shorter than DEB_LEN cycles SHALL never change gpio_sync.
REQ-022 Without EHL_GPIO_DEBOUNCE_EN, no counter logic SHALL exist, DEB_LEN SHALL be ignored, and latency is per REQ-007.

Verification
REQ-023 Rising edge: bit 3 has irq_type=1, irq_pol=1 and irq_en=1; gpio_in[3] 0->1 -> pending[3]=1 and irq=1 exactly SYNC_STAGES+1 edges later; gpio_sync[3]=1 one edge earlier.
REQ-024 Clear collision: pending[0]=1 in edge mode; clr_pend[0] is pulsed in the same cycle as a new event on bit 0 -> pending[0] stays 1; an isolated clr_pend[0] pulse afterwards -> pending[0]=0 on the next edge.
REQ-025 Level mode: bit 5 has irq_type=0 and irq_pol=0; gpio_in[5] held 0 with clr_pend[5] pulsed -> pending[5] stays 1; gpio_in[5] set to 1 then clr_pend[5] -> pending[5]=0.
REQ-026 Mask and software trigger: irq_en=0, then set_pend=32'h0000_0100 -> pending=32'h0000_0100 and irq=0; then irq_en[8]=1 -> irq=1 in the same cycle.
REQ-027 Both edges and reset: bit 1 has irq_both=1; a 0->1->0 pulse, with clears between the edges -> two separate pending events; reset_n asserted mid-pulse -> pending=0, gpio_sync=0 and irq=0 immediately.
REQ-028 Debounce (EHL_GPIO_DEBOUNCE_EN, DEB_LEN=4): a 3-cycle glitch on gpio_in[2] -> no gpio_sync change and no pending; a 10-cycle pulse -> gpio_sync[2] rises SYNC_STAGES+4 edges after the first sample.
